// File: rtl/rc5_key_loader_pkg.sv
// Shared RC5 constants plus the key-loader FSM encoding and its default sizing.
package rc5_key_loader_pkg;

  localparam int          W  = 32;
  localparam int          R  = 12;
  localparam logic [31:0] PW = 32'hB7E1_5163;
  localparam logic [31:0] QW = 32'h9E37_79B9;

  localparam int DEFAULT_B       = 16;
  localparam int DEFAULT_TIMEOUT = 255;
  localparam int WAIT_CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/rc5_key_loader_if.sv
// Key-byte stream, command handshake and core key/start/done signals of the loader.
interface rc5_key_loader_if #(
  parameter int B_LENGTH = 4
);
  logic                iKeyStart;
  logic [7:0]          iKeyByte;
  logic                iKeyValid;
  logic                oKeyReady;
  logic                iCmdValid;
  logic                iCmdOp;
  logic                oCmdReady;
  logic [7:0]          oKey_sub_i;
  logic [B_LENGTH-1:0] oKey_address;
  logic                oWen;
  logic                oStartCipher;
  logic                oStartDecipher;
  logic                iDoneCipher;
  logic                iDoneDecipher;
  logic                oKeyLoaded;
  logic                oBusy;
  logic                oDone;
  logic                oError;

  modport slave (
    input  iKeyStart, iKeyByte, iKeyValid, iCmdValid, iCmdOp, iDoneCipher, iDoneDecipher,
    output oKeyReady, oCmdReady, oKey_sub_i, oKey_address, oWen, oStartCipher,
           oStartDecipher, oKeyLoaded, oBusy, oDone, oError
  );

  modport master (
    output iKeyStart, iKeyByte, iKeyValid, iCmdValid, iCmdOp, iDoneCipher, iDoneDecipher,
    input  oKeyReady, oCmdReady, oKey_sub_i, oKey_address, oWen, oStartCipher,
           oStartDecipher, oKeyLoaded, oBusy, oDone, oError
  );
endinterface

// File: rtl/rc5_key_loader.sv
// Streams a B-byte key into the RC5 core key memory, then launches cipher/decipher
// operations and waits for the core's done edge with a bounded timeout.
module rc5_key_loader
  import rc5_key_loader_pkg::*;
#(
  parameter int B        = DEFAULT_B,
  parameter int B_LENGTH = $clog2(B),
  parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
  input logic            clk,
  input logic            rst,
  rc5_key_loader_if.slave bus
);

  state_e                r_state;
  logic [B_LENGTH-1:0]   r_key_cnt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_op;
  logic                  r_done_prev;
  logic                  r_wen;
  logic [7:0]            r_key_byte;
  logic [B_LENGTH-1:0]   r_key_addr;
  logic                  r_start_cipher;
  logic                  r_start_decipher;
  logic                  r_key_loaded;
  logic                  r_done;
  logic                  r_error;

  logic                  w_done_sel;
  logic                  w_done_edge;
  logic                  w_cmd_ready;
  logic [WAIT_CNT_W-1:0] w_wait_next;

  // Done level of the core selected by the latched operation.
  always_comb begin
    if (r_op) begin
      w_done_sel = bus.iDoneDecipher;
    end else begin
      w_done_sel = bus.iDoneCipher;
    end
  end

  assign w_done_edge = w_done_sel & ~r_done_prev;
  assign w_cmd_ready = (r_state == ST_IDLE) & r_key_loaded & ~bus.iKeyStart;
  assign w_wait_next = r_wait_cnt + 8'd1;

  // Main FSM: key streaming, start pulse generation and done/timeout tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= ST_IDLE;
      r_key_cnt        <= '0;
      r_wait_cnt       <= '0;
      r_op             <= 1'b0;
      r_done_prev      <= 1'b0;
      r_wen            <= 1'b0;
      r_key_byte       <= 8'd0;
      r_key_addr       <= '0;
      r_start_cipher   <= 1'b0;
      r_start_decipher <= 1'b0;
      r_key_loaded     <= 1'b0;
      r_done           <= 1'b0;
      r_error          <= 1'b0;
    end else begin
      r_wen            <= 1'b0;
      r_start_cipher   <= 1'b0;
      r_start_decipher <= 1'b0;
      r_done           <= 1'b0;
      r_error          <= 1'b0;
      r_done_prev      <= w_done_sel;
      case (r_state)
        ST_IDLE: begin
          if (bus.iKeyStart) begin
            r_key_cnt    <= '0;
            r_key_loaded <= 1'b0;
            r_state      <= ST_LOAD;
          end else if (bus.iCmdValid && w_cmd_ready) begin
            r_op             <= bus.iCmdOp;
            r_start_cipher   <= ~bus.iCmdOp;
            r_start_decipher <= bus.iCmdOp;
            r_state          <= ST_START;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (bus.iKeyValid) begin
            r_wen      <= 1'b1;
            r_key_byte <= bus.iKeyByte;
            r_key_addr <= r_key_cnt;
            if (r_key_cnt == B_LENGTH'(B - 1)) begin
              r_key_cnt    <= '0;
              r_key_loaded <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_key_cnt <= r_key_cnt + B_LENGTH'(1);
            end
          end else begin
            r_state <= ST_LOAD;
          end
        end
        ST_START: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          r_wait_cnt <= w_wait_next;
          // A done edge takes priority over a simultaneous timeout.
          if (w_done_edge) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_wait_next == WAIT_CNT_W'(TIMEOUT)) begin
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.oKeyReady      = (r_state == ST_LOAD);
  assign bus.oCmdReady      = w_cmd_ready;
  assign bus.oKey_sub_i     = r_key_byte;
  assign bus.oKey_address   = r_key_addr;
  assign bus.oWen           = r_wen;
  assign bus.oStartCipher   = r_start_cipher;
  assign bus.oStartDecipher = r_start_decipher;
  assign bus.oKeyLoaded     = r_key_loaded;
  assign bus.oBusy          = (r_state != ST_IDLE);
  assign bus.oDone          = r_done;
  assign bus.oError         = r_error;

endmodule

// File: tb/tb_rc5_key_loader.sv
// Self-checking bench for rc5_key_loader: write scoreboard plus directed command,
// stale-done, timeout and mid-load reset scenarios.
module tb_rc5_key_loader;
  import rc5_key_loader_pkg::*;

  localparam int B  = DEFAULT_B;
  localparam int BL = $clog2(B);
  localparam int TO = DEFAULT_TIMEOUT;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rc5_key_loader_if #(.B_LENGTH(BL)) bus ();

  rc5_key_loader #(.B(B), .B_LENGTH(BL), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_wen    = 0;
  logic [BL+7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.oWen, bus.oKey_sub_i, bus.oKey_address, bus.oStartCipher,
                bus.oStartDecipher, bus.oDone, bus.oError, bus.oKeyLoaded,
                bus.oBusy, bus.oKeyReady, bus.oCmdReady});
  endfunction

  // Every key-memory write must match the oldest expected {address, byte}.
  always @(negedge clk) begin
    if (bus.oWen === 1'b1) begin
      n_wen++;
      check_eq("wen_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [BL+7:0] e;
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(bus.oKey_address), 32'(e[BL+7:8]));
        check_eq("wr_data", 32'(bus.oKey_sub_i), 32'(e[7:0]));
      end
    end
  end

  // Called at posedge+1; returns at a negedge with the key loaded.
  task automatic load_key(input int base, input bit gapped, input bit with_cmd);
    int w0;
    bus.iKeyStart = 1'b1;
    bus.iCmdValid = with_cmd;
    bus.iCmdOp    = 1'b0;
    @(negedge clk);
    if (with_cmd) check_eq("start_beats_cmd", 32'(bus.oCmdReady), 32'd0);
    tick();
    bus.iKeyStart = 1'b0;
    bus.iCmdValid = 1'b0;
    @(negedge clk);
    check_eq("load_entry", 32'({bus.oKeyReady, bus.oBusy, bus.oKeyLoaded, bus.oStartCipher}),
             32'(4'b1100));
    w0 = n_wen;
    tick();
    for (int i = 0; i < B; i++) begin
      if (gapped) begin
        bus.iKeyValid = 1'b0;
        tick();
      end
      bus.iKeyValid = 1'b1;
      bus.iKeyByte  = 8'(base + i);
      exp_q.push_back({BL'(i), 8'(base + i)});
      tick();
    end
    bus.iKeyValid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    check_eq("load_writes", 32'(n_wen - w0), 32'(B));
    check_eq("load_queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("load_done_flags", 32'({bus.oKeyLoaded, bus.oKeyReady, bus.oBusy}), 32'(3'b100));
  endtask

  // Called at posedge+1; returns at the negedge of the first WAIT cycle.
  task automatic issue_cmd(input bit op);
    bus.iCmdValid = 1'b1;
    bus.iCmdOp    = op;
    @(negedge clk);
    check_eq("cmd_ready", 32'(bus.oCmdReady), 32'd1);
    tick();
    bus.iCmdValid = 1'b0;
    @(negedge clk);
    check_eq("start_pulse", 32'({bus.oStartCipher, bus.oStartDecipher, bus.oBusy}),
             32'({~op, op, 1'b1}));
    tick();
    @(negedge clk);
    check_eq("start_one_cycle", 32'({bus.oStartCipher, bus.oStartDecipher, bus.oBusy}),
             32'(3'b001));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int n;
    bus.iKeyStart     = 1'b0;
    bus.iKeyByte      = 8'd0;
    bus.iKeyValid     = 1'b0;
    bus.iCmdValid     = 1'b0;
    bus.iCmdOp        = 1'b0;
    bus.iDoneCipher   = 1'b0;
    bus.iDoneDecipher = 1'b0;

    @(negedge clk);
    check_eq("reset_outs", all_outs(), 32'd0);
    tick();
    rst = 1'b1;

    // Command without a loaded key is dropped.
    tick();
    bus.iCmdValid = 1'b1;
    @(negedge clk);
    check_eq("cmd_not_ready", 32'(bus.oCmdReady), 32'd0);
    tick();
    bus.iCmdValid = 1'b0;
    @(negedge clk);
    check_eq("cmd_ignored", 32'({bus.oBusy, bus.oStartCipher, bus.oStartDecipher}), 32'd0);

    tick();
    load_key(32'h00, 1'b0, 1'b0);

    // Cipher: done rises 20 cycles after the start pulse.
    tick();
    issue_cmd(1'b0);
    seen = 1'b0;
    repeat (19) begin
      tick();
      @(negedge clk);
      if (bus.oDone) seen = 1'b1;
    end
    check_eq("cipher_no_early_done", 32'(seen), 32'd0);
    tick();
    bus.iDoneCipher = 1'b1;
    tick();
    @(negedge clk);
    check_eq("cipher_done", 32'({bus.oDone, bus.oError}), 32'(2'b10));
    tick();
    bus.iDoneCipher = 1'b0;
    @(negedge clk);
    check_eq("cipher_idle", 32'({bus.oDone, bus.oBusy, bus.oKeyLoaded}), 32'(3'b001));

    tick();
    load_key(32'h30, 1'b1, 1'b1);

    // Stale decipher done level must not complete the operation.
    tick();
    bus.iDoneDecipher = 1'b1;
    tick();
    tick();
    issue_cmd(1'b1);
    seen = 1'b0;
    repeat (10) begin
      tick();
      @(negedge clk);
      if (bus.oDone) seen = 1'b1;
    end
    check_eq("stale_no_done", 32'({seen, bus.oBusy}), 32'(2'b01));
    tick();
    bus.iDoneDecipher = 1'b0;
    tick();
    tick();
    bus.iDoneDecipher = 1'b1;
    tick();
    @(negedge clk);
    check_eq("stale_then_edge_done", 32'(bus.oDone), 32'd1);
    tick();
    bus.iDoneDecipher = 1'b0;
    @(negedge clk);
    check_eq("stale_idle", 32'({bus.oDone, bus.oBusy}), 32'd0);

    // Timeout: no done at all.
    tick();
    issue_cmd(1'b0);
    n = 0;
    seen = 1'b0;
    while (n < TO + 20 && !seen) begin
      tick();
      n++;
      @(negedge clk);
      if (bus.oError) seen = 1'b1;
    end
    check_eq("timeout_seen", 32'(seen), 32'd1);
    check_eq("timeout_cycles", 32'(n), 32'(TO));
    check_eq("timeout_no_done", 32'(bus.oDone), 32'd0);
    tick();
    @(negedge clk);
    check_eq("timeout_idle", 32'({bus.oError, bus.oBusy, bus.oKeyLoaded}), 32'(3'b001));

    // Reset after byte 7 of a new load, then reload from address 0.
    tick();
    bus.iKeyStart = 1'b1;
    tick();
    bus.iKeyStart = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.iKeyValid = 1'b1;
      bus.iKeyByte  = 8'(32'hA0 + i);
      exp_q.push_back({BL'(i), 8'(32'hA0 + i)});
      tick();
    end
    bus.iKeyValid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("midload_reset_outs", all_outs(), 32'd0);
    check_eq("midload_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_eq("after_reset_unloaded", 32'({bus.oKeyLoaded, bus.oCmdReady, bus.oBusy}), 32'd0);
    tick();
    load_key(32'h50, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
